// File: rtl/dct_coeff_quantizer.sv
`default_nettype none
// ============================================================================
// Module      : dct_coeff_quantizer
// Description : Reads the 8 DCT coefficients back from the result EBR.
//               Scales each one by a per-index reciprocal, then rounds or
//               truncates and saturates the result to a signed byte.
//               The bytes are streamed out over a valid/ready port.
//               Optional macro DCT_QUANT_ROUND_EN selects round-half-up
//               instead of arithmetic-shift truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_coeff_quantizer #(
    parameter int COEF_WIDTH  = 16,
    parameter int RECIP_WIDTH = 16,
    parameter int SHIFT       = 16,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               coef_addr,
    output logic                     coef_clk,
    input  logic [COEF_WIDTH-1:0]    coef_data,
    input  logic [8*RECIP_WIDTH-1:0] quant_recip,
    output logic [OUT_WIDTH-1:0]     q_data,
    output logic [2:0]               q_index,
    output logic                     q_valid,
    input  logic                     q_ready
);

    localparam int c_prod_w = COEF_WIDTH + RECIP_WIDTH + 1;
    localparam int c_sum_w  = c_prod_w + 1;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_fetch   = 3'd1;
    localparam logic [2:0] c_st_capture = 3'd2;
    localparam logic [2:0] c_st_round   = 3'd3;
    localparam logic [2:0] c_st_emit    = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;

`ifdef DCT_QUANT_ROUND_EN
    localparam logic signed [c_sum_w-1:0] c_rnd = {{(c_sum_w-1){1'b0}}, 1'b1} << (SHIFT-1);
`else
    localparam logic signed [c_sum_w-1:0] c_rnd = '0;
`endif

    localparam logic signed [c_sum_w-1:0] c_sat_max = c_sum_w'((2**(OUT_WIDTH-1)) - 1);
    localparam logic signed [c_sum_w-1:0] c_sat_min = -c_sat_max - c_sum_w'(1);

    logic [2:0]                   r_state;
    logic [2:0]                   w_state_nxt;
    logic [2:0]                   r_idx;
    logic signed [c_prod_w-1:0]   r_prod;
    logic signed [c_prod_w-1:0]   w_prod;
    logic signed [c_sum_w-1:0]    w_sum;
    logic signed [c_sum_w-1:0]    w_shift;
    logic [OUT_WIDTH-1:0]         w_sat;
    logic                         w_handshake;
    logic [RECIP_WIDTH-1:0]       w_recip [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_recip
            assign w_recip[gi] = quant_recip[gi*RECIP_WIDTH +: RECIP_WIDTH];
        end
    endgenerate

    assign coef_clk    = clock;
    assign busy        = (r_state != c_st_idle) && (r_state != c_st_done);
    assign done        = (r_state == c_st_done);
    assign w_handshake = q_valid && q_ready;

    // Reciprocal is unsigned: zero-extend it before the signed multiply.
    assign w_prod  = c_prod_w'($signed(coef_data)) * c_prod_w'($signed({1'b0, w_recip[r_idx]}));
    assign w_sum   = c_sum_w'(r_prod) + c_rnd;
    assign w_shift = w_sum >>> SHIFT;

    always_comb begin
        w_sat = w_shift[OUT_WIDTH-1:0];
        if (w_shift > c_sat_max) begin
            w_sat = c_sat_max[OUT_WIDTH-1:0];
        end else if (w_shift < c_sat_min) begin
            w_sat = c_sat_min[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (start) w_state_nxt = c_st_fetch;
            c_st_fetch:   w_state_nxt = c_st_capture;
            c_st_capture: w_state_nxt = c_st_round;
            c_st_round:   w_state_nxt = c_st_emit;
            c_st_emit: begin
                if (w_handshake) begin
                    w_state_nxt = (r_idx == 3'd7) ? c_st_done : c_st_fetch;
                end
            end
            c_st_done:    w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx     <= '0;
            r_prod    <= '0;
            coef_addr <= '0;
            q_data    <= '0;
            q_index   <= '0;
            q_valid   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_idx     <= '0;
                        coef_addr <= '0;
                    end
                end
                c_st_capture: r_prod <= w_prod;
                c_st_round: begin
                    q_data  <= w_sat;
                    q_index <= r_idx;
                    q_valid <= 1'b1;
                end
                c_st_emit: begin
                    // coef_addr only moves on a handshake, so a stall issues no new read.
                    if (w_handshake) begin
                        q_valid <= 1'b0;
                        if (r_idx != 3'd7) begin
                            r_idx     <= r_idx + 3'd1;
                            coef_addr <= r_idx + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct_coeff_quantizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_coeff_quantizer
// Description : Self-checking bench for dct_coeff_quantizer with a behavioural
//               EBR model, a directed vector table and random blocks.
//               Honours DCT_QUANT_ROUND_EN in its expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_coeff_quantizer;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         busy;
    logic         done;
    logic [2:0]   coef_addr;
    logic         coef_clk;
    logic [15:0]  coef_data;
    logic [127:0] quant_recip;
    logic [7:0]   q_data;
    logic [2:0]   q_index;
    logic         q_valid;
    logic         q_ready;

    typedef struct {
        logic [15:0] coef;
        logic [15:0] recip;
        logic [7:0]  q;
    } vec_t;

    vec_t        vecs [16];
    logic [15:0] mem [8];
    logic [7:0]  exp_q [8];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

`ifdef DCT_QUANT_ROUND_EN
    localparam logic [7:0] c_half_pos = 8'h01;
    localparam logic [7:0] c_half_neg = 8'h00;
`else
    localparam logic [7:0] c_half_pos = 8'h00;
    localparam logic [7:0] c_half_neg = 8'hFF;
`endif

    dct_coeff_quantizer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .coef_addr   (coef_addr),
        .coef_clk    (coef_clk),
        .coef_data   (coef_data),
        .quant_recip (quant_recip),
        .q_data      (q_data),
        .q_index     (q_index),
        .q_valid     (q_valid),
        .q_ready     (q_ready)
    );

    always #5 clock = ~clock;

    // Synchronous-read EBR: dout follows the address sampled on the previous edge.
    always @(posedge coef_clk) coef_data <= mem[coef_addr];

    // Reference: exact product, optional half-LSB bias, floor division by 2^16, clamp.
    function automatic logic [7:0] model(input logic [15:0] c, input logic [15:0] r);
        longint p;
        longint q;
        p = longint'($signed(c)) * longint'({48'd0, r});
`ifdef DCT_QUANT_ROUND_EN
        p = p + 32768;
`endif
        q = p / 65536;
        if ((p % 65536) != 0 && p < 0) q = q - 1;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic load_block(input int base);
        for (int i = 0; i < 8; i++) begin
            mem[i]                 = vecs[base+i].coef;
            quant_recip[i*16 +: 16] = vecs[base+i].recip;
            exp_q[i]               = vecs[base+i].q;
        end
    endtask

    task automatic run_block(input int stall_at, input int stall_len, input bit timing, input bit poke);
        int guard;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc   = 0;
        check("busy_after_start", busy, 1);
        for (int k = 0; k < 8; k++) begin
            guard = 0;
            while (!q_valid && guard < 40) begin
                step();
                guard++;
            end
            if (!q_valid) begin
                check("q_valid_timeout", q_valid, 1);
                return;
            end
            check("q_index", q_index, k);
            check("q_data", q_data, exp_q[k]);
            if (timing) check("valid_latency", cyc, 4*k + 3);
            if (k == stall_at && stall_len > 0) begin
                q_ready = 1'b0;
                repeat (stall_len) begin
                    step();
                    check("stall_data", q_data, exp_q[k]);
                    check("stall_index", q_index, k);
                    check("stall_valid", q_valid, 1);
                    check("stall_addr", coef_addr, k);
                end
                q_ready = 1'b1;
            end
            if (poke && k == 2) start = 1'b1;
            step();
            start = 1'b0;
            check("valid_dropped", q_valid, 0);
        end
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        // done occupies the cycle that ends at edge 33 after the start edge.
        if (timing) check("done_latency", cyc, 32);
        step();
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        q_ready     = 1'b1;
        quant_recip = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        for (int i = 0; i < 8; i++) vecs[i] = '{16'h0100, 16'h0800, 8'h08};
        vecs[8]  = '{16'h0010, 16'h0800, c_half_pos};
        vecs[9]  = '{16'hFFF0, 16'h0800, c_half_neg};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 8'h7F};
        vecs[11] = '{16'h8000, 16'hFFFF, 8'h80};
        vecs[12] = '{16'h1234, 16'h0000, 8'h00};
        vecs[13] = '{16'h0300, 16'h0800, 8'h18};
        vecs[14] = '{16'hFE00, 16'h1000, 8'hE0};
        vecs[15] = '{16'h0100, 16'h7F00, 8'h7F};

        #12;
        check("rst_addr", coef_addr, 0);
        check("rst_qdata", q_data, 0);
        check("rst_qindex", q_index, 0);
        check("rst_qvalid", q_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        step();

        // Uniform block with exact latency checks.
        load_block(0);
        run_block(-1, 0, 1'b1, 1'b0);

        // Rounding ties, saturation and zero reciprocal.
        load_block(8);
        run_block(-1, 0, 1'b1, 1'b0);

        // Back-pressure on index 3.
        load_block(0);
        run_block(3, 6, 1'b0, 1'b0);

        // Reset while capturing index 5, then restart with a stray start pulse.
        load_block(0);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (21) step();
        check("pre_reset_addr", coef_addr, 5);
        reset = 1'b1;
        #1;
        check("mid_rst_addr", coef_addr, 0);
        check("mid_rst_qdata", q_data, 0);
        check("mid_rst_qindex", q_index, 0);
        check("mid_rst_qvalid", q_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        step();
        load_block(8);
        run_block(-1, 0, 1'b1, 1'b1);

        // Random blocks against the reference model, with random short stalls.
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < 8; i++) begin
                logic [15:0] c;
                logic [15:0] r;
                if ($urandom_range(0, 1) == 0) c = 16'($urandom);
                else c = 16'(int'($urandom_range(0, 2047)) - 1024);
                r = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
                mem[i]                  = c;
                quant_recip[i*16 +: 16] = r;
                exp_q[i]                = model(c, r);
            end
            run_block($urandom_range(0, 7), $urandom_range(0, 3), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
